// File: rtl/sec08_queues_param_queue.sv
// Parametrised N-entry val/rdy queue with normal, pipe, bypass and
// pipe+bypass flow-through modes, synchronous clear and free-slot count.
module sec08_queues_param_queue #(
    parameter int p_msg_nbits = 32,
    parameter int p_num_msgs  = 4,
    parameter int p_type      = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              istream_val,
    output logic                              istream_rdy,
    input  logic [p_msg_nbits-1:0]            istream_msg,
    output logic                              ostream_val,
    input  logic                              ostream_rdy,
    output logic [p_msg_nbits-1:0]            ostream_msg,
    output logic [$clog2(p_num_msgs+1)-1:0]   num_free_entries
);

    localparam int AW = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
    localparam int CW = $clog2(p_num_msgs + 1);

    typedef enum logic [1:0] {
        QT_NORMAL      = 2'd0,
        QT_PIPE        = 2'd1,
        QT_BYPASS      = 2'd2,
        QT_PIPE_BYPASS = 2'd3
    } qtype_e;

    localparam qtype_e QTYPE       = qtype_e'(2'(p_type));
    localparam bit     PIPE_MODE   = (QTYPE == QT_PIPE)   || (QTYPE == QT_PIPE_BYPASS);
    localparam bit     BYPASS_MODE = (QTYPE == QT_BYPASS) || (QTYPE == QT_PIPE_BYPASS);

    logic [p_msg_nbits-1:0] storage [p_num_msgs];
    logic [AW-1:0]          enq_ptr;
    logic [AW-1:0]          deq_ptr;
    logic [CW-1:0]          count;

    logic full;
    logic empty;
    logic active;
    logic enq_fire;
    logic deq_fire;
    logic bypass_through;
    logic wr_en;
    logic rd_en;

    // Explicit wrap so non-power-of-2 depths never index past the last slot.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(p_num_msgs - 1)) ? '0 : p + AW'(1);
    endfunction

    // Handshake, flow-through and output datapath decode.
    always_comb begin
        full             = (count == CW'(p_num_msgs));
        empty            = (count == '0);
        active           = reset & ~clear;
        istream_rdy      = active & (~full | (PIPE_MODE & ostream_rdy));
        ostream_val      = active & (~empty | (BYPASS_MODE & istream_val));
        enq_fire         = istream_val & istream_rdy;
        deq_fire         = ostream_val & ostream_rdy;
        bypass_through   = BYPASS_MODE & empty & enq_fire & deq_fire;
        wr_en            = enq_fire & ~bypass_through;
        rd_en            = deq_fire & ~empty;
        num_free_entries = CW'(p_num_msgs) - count;
        ostream_msg      = '0;
        if (reset) begin
            if (!empty)
                ostream_msg = storage[deq_ptr];
            else if (BYPASS_MODE)
                ostream_msg = istream_msg;
        end
    end

    // Pointer and occupancy state; clear wins over any transfer that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            count   <= '0;
        end else if (clear) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            count   <= '0;
        end else begin
            if (wr_en)
                enq_ptr <= next_ptr(enq_ptr);
            if (rd_en)
                deq_ptr <= next_ptr(deq_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Message storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            storage[enq_ptr] <= istream_msg;
    end

endmodule

// File: tb/tb_sec08_queues_param_queue.sv
// Bench for sec08_queues_param_queue: five configurations driven in parallel
// and compared every cycle against queue-based reference models.
module tb_sec08_queues_param_queue;

    localparam int NI = 5;
    localparam int NQ [NI] = '{4, 3, 2, 1, 3};
    localparam int TQ [NI] = '{0, 0, 1, 2, 3};

    logic clk = 1'b0;
    logic reset;
    logic [NI-1:0]      ival, ordy, clr, irdy, oval;
    logic [NI-1:0][7:0] imsg, omsg;
    logic [2:0] nf0;
    logic [1:0] nf1, nf2, nf4;
    logic [0:0] nf3;
    int         nf [NI];

    logic [7:0] mq [NI][$];
    bit enqf [NI];
    bit deqf [NI];
    bit thrf [NI];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always_comb begin
        nf[0] = int'(nf0);
        nf[1] = int'(nf1);
        nf[2] = int'(nf2);
        nf[3] = int'(nf3);
        nf[4] = int'(nf4);
    end

    sec08_queues_param_queue #(.p_msg_nbits(8), .p_num_msgs(4), .p_type(0)) u_q0 (
        .clk(clk), .reset(reset), .clear(clr[0]),
        .istream_val(ival[0]), .istream_rdy(irdy[0]), .istream_msg(imsg[0]),
        .ostream_val(oval[0]), .ostream_rdy(ordy[0]), .ostream_msg(omsg[0]),
        .num_free_entries(nf0));
    sec08_queues_param_queue #(.p_msg_nbits(8), .p_num_msgs(3), .p_type(0)) u_q1 (
        .clk(clk), .reset(reset), .clear(clr[1]),
        .istream_val(ival[1]), .istream_rdy(irdy[1]), .istream_msg(imsg[1]),
        .ostream_val(oval[1]), .ostream_rdy(ordy[1]), .ostream_msg(omsg[1]),
        .num_free_entries(nf1));
    sec08_queues_param_queue #(.p_msg_nbits(8), .p_num_msgs(2), .p_type(1)) u_q2 (
        .clk(clk), .reset(reset), .clear(clr[2]),
        .istream_val(ival[2]), .istream_rdy(irdy[2]), .istream_msg(imsg[2]),
        .ostream_val(oval[2]), .ostream_rdy(ordy[2]), .ostream_msg(omsg[2]),
        .num_free_entries(nf2));
    sec08_queues_param_queue #(.p_msg_nbits(8), .p_num_msgs(1), .p_type(2)) u_q3 (
        .clk(clk), .reset(reset), .clear(clr[3]),
        .istream_val(ival[3]), .istream_rdy(irdy[3]), .istream_msg(imsg[3]),
        .ostream_val(oval[3]), .ostream_rdy(ordy[3]), .ostream_msg(omsg[3]),
        .num_free_entries(nf3));
    sec08_queues_param_queue #(.p_msg_nbits(8), .p_num_msgs(3), .p_type(3)) u_q4 (
        .clk(clk), .reset(reset), .clear(clr[4]),
        .istream_val(ival[4]), .istream_rdy(irdy[4]), .istream_msg(imsg[4]),
        .ostream_val(oval[4]), .ostream_rdy(ordy[4]), .ostream_msg(omsg[4]),
        .num_free_entries(nf4));

    function automatic void chk(string nm, int k, int got, int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s[q%0d]: got %0h expected %0h at %0t", nm, k, got, exp, $time);
    endfunction

    task automatic idle();
        ival = '0;
        ordy = '0;
        clr  = '0;
        imsg = '0;
    endtask

    // Check all queues against their models mid-cycle, then advance models at the edge.
    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            int cnt;
            bit pipe, byp, e_irdy, e_oval;
            cnt    = mq[k].size();
            pipe   = (TQ[k] == 1) || (TQ[k] == 3);
            byp    = (TQ[k] >= 2);
            e_irdy = !clr[k] && ((cnt < NQ[k]) || (pipe && ordy[k]));
            e_oval = !clr[k] && ((cnt > 0) || (byp && ival[k]));
            chk("istream_rdy", k, int'(irdy[k]), int'(e_irdy));
            chk("ostream_val", k, int'(oval[k]), int'(e_oval));
            if (e_oval)
                chk("ostream_msg", k, int'(omsg[k]), (cnt > 0) ? int'(mq[k][0]) : int'(imsg[k]));
            chk("num_free", k, nf[k], NQ[k] - cnt);
            enqf[k] = ival[k] && e_irdy;
            deqf[k] = e_oval && ordy[k];
            thrf[k] = byp && (cnt == 0) && enqf[k] && deqf[k];
        end
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (clr[k]) begin
                mq[k].delete();
            end else begin
                if (deqf[k] && mq[k].size() > 0)
                    void'(mq[k].pop_front());
                if (enqf[k] && !thrf[k])
                    mq[k].push_back(imsg[k]);
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_irdy", k, int'(irdy[k]), 0);
            chk("rst_oval", k, int'(oval[k]), 0);
            chk("rst_omsg", k, int'(omsg[k]), 0);
            chk("rst_nfree", k, nf[k], NQ[k]);
        end
        reset = 1'b1;
        cycle();

        // Normal N=4: fill without draining, then drain in order.
        for (int i = 0; i < 4; i++) begin
            ival[0] = 1'b1;
            imsg[0] = 8'hA0 + 8'(i);
            cycle();
        end
        ival[0] = 1'b0;
        #1;
        chk("t1_rdy_full", 0, int'(irdy[0]), 0);
        chk("t1_nfree_full", 0, nf[0], 0);
        ordy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t1_drain_val", 0, int'(oval[0]), 1);
            chk("t1_drain_msg", 0, int'(omsg[0]), 'hA0 + i);
            cycle();
        end
        idle();
        cycle();

        // Pipe N=2: enqueue into a full queue while it is being drained.
        ival[2] = 1'b1; imsg[2] = 8'h11; cycle();
        imsg[2] = 8'h22; cycle();
        imsg[2] = 8'h33; ordy[2] = 1'b1;
        #1;
        chk("t3_rdy_full_pipe", 2, int'(irdy[2]), 1);
        chk("t3_msg0", 2, int'(omsg[2]), 'h11);
        cycle();
        ival[2] = 1'b0;
        #1;
        chk("t3_nfree", 2, nf[2], 0);
        chk("t3_msg1", 2, int'(omsg[2]), 'h22);
        cycle();
        #1;
        chk("t3_msg2", 2, int'(omsg[2]), 'h33);
        cycle();
        idle();
        cycle();

        // Bypass N=1: flow-through when empty, storage when stalled.
        ival[3] = 1'b1; imsg[3] = 8'h55; ordy[3] = 1'b1;
        #1;
        chk("t4_byp_val", 3, int'(oval[3]), 1);
        chk("t4_byp_msg", 3, int'(omsg[3]), 'h55);
        cycle();
        #1;
        chk("t4_byp_nfree", 3, nf[3], 1);
        ordy[3] = 1'b0;
        cycle();
        ival[3] = 1'b0;
        #1;
        chk("t4_stored_rdy", 3, int'(irdy[3]), 0);
        chk("t4_stored_msg", 3, int'(omsg[3]), 'h55);
        ordy[3] = 1'b1;
        cycle();
        idle();
        cycle();

        // Clear with a pending enqueue.
        for (int i = 0; i < 3; i++) begin
            ival[0] = 1'b1;
            imsg[0] = 8'hC0 + 8'(i);
            cycle();
        end
        clr[0] = 1'b1; imsg[0] = 8'hC3;
        #1;
        chk("t5_clr_rdy", 0, int'(irdy[0]), 0);
        chk("t5_clr_val", 0, int'(oval[0]), 0);
        cycle();
        idle();
        #1;
        chk("t5_nfree", 0, nf[0], 4);
        chk("t5_val", 0, int'(oval[0]), 0);
        cycle();

        // Asynchronous reset between edges with data held.
        ival[0] = 1'b1; imsg[0] = 8'hD0; cycle();
        imsg[0] = 8'hD1; cycle();
        idle();
        #1;
        reset = 1'b0;
        #1;
        chk("t6_val", 0, int'(oval[0]), 0);
        chk("t6_nfree", 0, nf[0], 4);
        chk("t6_rdy", 0, int'(irdy[0]), 0);
        for (int k = 0; k < NI; k++)
            mq[k].delete();
        @(posedge clk);
        #3;
        reset = 1'b1;
        ival[0] = 1'b1; imsg[0] = 8'h77;
        cycle();
        ival[0] = 1'b0; ordy[0] = 1'b1;
        #1;
        chk("t6_deq_msg", 0, int'(omsg[0]), 'h77);
        cycle();
        idle();
        for (int k = 0; k < NI; k++)
            enqf[k] = 1'b0;

        // Random traffic with producer hold, occasional clear.
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NI; k++) begin
                if (!(ival[k] && !enqf[k])) begin
                    ival[k] = ($urandom_range(0, 99) < 60);
                    imsg[k] = 8'($urandom);
                end
                ordy[k] = ($urandom_range(0, 99) < ((c < 400) ? 30 : 80));
                clr[k]  = ($urandom_range(0, 99) < 3);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
